lane_transpose: RTL and testbench

LANE_TRANSPOSE -- requirements
Module: lane_transpose

---
 rtl/lane_transpose_pkg.sv | 25 ++
 rtl/lane_transpose_bank.sv | 37 +++
 rtl/lane_transpose.sv | 127 ++++++++++++
 tb/tb_lane_transpose.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_transpose_pkg.sv
// ---------------------------------------------------------------
// lane_transpose_pkg : shared lane/data types for the transpose. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

`ifndef R
`define R 8
`endif
`ifndef M
`define M 16
`endif

package lane_transpose_pkg;

  typedef logic [`M-1:0] data_t;
  typedef data_t [`R-1:0] lane_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/lane_transpose_bank.sv
// ---------------------------------------------------------------
// transpose_bank : LANES x LANES register array, row write / column read. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module transpose_bank
  import lane_transpose_pkg::*;
#(
  parameter int LANES     = `R,
  parameter int CNT_WIDTH = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   wr_en_i,
  input  logic [CNT_WIDTH-1:0]   wr_row_i,
  input  data_t [LANES-1:0]      wr_data_i,
  input  logic [CNT_WIDTH-1:0]   rd_col_i,
  output data_t [LANES-1:0]      rd_data_o
);

  data_t [LANES-1:0] mem_q [LANES];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  // The row written this cycle is forwarded so a column can be read on the
  // same edge that completes the bank.
  for (genvar g = 0; g < LANES; g++) begin : g_row
    assign rd_data_o[g] = (wr_en_i && (wr_row_i == CNT_WIDTH'(g))) ?
                          wr_data_i[rd_col_i] : mem_q[g][rd_col_i];
  end

endmodule

`default_nettype wire

// File: rtl/lane_transpose.sv
// ---------------------------------------------------------------
// lane_transpose : ping-pong LANES x LANES transpose, beat k lane i = in beat i lane k. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module lane_transpose
  import lane_transpose_pkg::*;
#(
  parameter int LANES     = `R,
  parameter int CNT_WIDTH = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  data_t [LANES-1:0]   lane_in,
  input  logic                clear,
  output logic                valid_out,
  output data_t [LANES-1:0]   lane_out
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LANES - 1);

  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           full_q, full_d;
  rd_state_t            state_q;
  logic                 rd_bank_q;
  logic [CNT_WIDTH-1:0] rd_cnt_q;

  logic                 w_wr_en;
  logic                 w_wr_last;
  logic [1:0]           w_full_now;
  logic                 w_emit;
  logic                 w_rd_last;
  data_t [LANES-1:0]    w_col [2];
  data_t [LANES-1:0]    w_rd_col;

  assign w_wr_en   = valid_in && !clear;
  assign w_wr_last = w_wr_en && (wr_cnt_q == LAST);

  // A bank completing on this edge already counts as full, so reading starts
  // on the same edge and the first output beat has no extra bubble.
  assign w_full_now = full_q | (w_wr_last ? (2'b01 << wr_ptr_q) : 2'b00);
  assign w_emit     = !clear && w_full_now[rd_bank_q];
  assign w_rd_last  = w_emit && (rd_cnt_q == LAST);
  assign w_rd_col   = rd_bank_q ? w_col[1] : w_col[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .LANES     (LANES),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_bank (
      .clk       (clk),
      .wr_en_i   (w_wr_en && (wr_ptr_q == 1'(b))),
      .wr_row_i  (wr_cnt_q),
      .wr_data_i (lane_in),
      .rd_col_i  (rd_cnt_q),
      .rd_data_o (w_col[b])
    );
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    if (clear) begin
      wr_cnt_d = '0;
      full_d   = '0;
    end else begin
      if (w_wr_last) begin
        wr_cnt_d         = '0;
        wr_ptr_d         = ~wr_ptr_q;
        full_d[wr_ptr_q] = 1'b1;
      end else if (w_wr_en) begin
        wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
      end
      if (w_rd_last) begin
        full_d[rd_bank_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      wr_ptr_q <= 1'b0;
      full_q   <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
    end
  end

  // READ persists across block boundaries while the other bank is full,
  // which keeps back-to-back blocks contiguous on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      valid_out <= 1'b0;
      lane_out  <= '0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= wr_ptr_q;
      valid_out <= 1'b0;
    end else if (w_emit) begin
      state_q   <= ST_READ;
      valid_out <= 1'b1;
      lane_out  <= w_rd_col;
      if (w_rd_last) begin
        rd_cnt_q  <= '0;
        rd_bank_q <= ~rd_bank_q;
      end else begin
        rd_cnt_q  <= rd_cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      state_q   <= ST_IDLE;
      valid_out <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lane_transpose.sv
// ---------------------------------------------------------------
// tb_lane_transpose : directed + random checks of lane_transpose against a queue model. rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_lane_transpose;
  import lane_transpose_pkg::*;

  localparam int L = `R;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  valid_in;
  logic  clear;
  lane_t lane_in;
  logic  valid_out;
  lane_t lane_out;

  int tests = 0;
  int fails = 0;

  // Reference: completed blocks are transposed into a FIFO of output beats,
  // and one pending beat leaves the FIFO per clock edge.
  lane_t blk_q[$];
  lane_t pend_q[$];
  lane_t exp_out;
  logic  exp_v;
  int    dut_valid_cnt;
  int    blocks_done;

  always #5 clk = ~clk;

  lane_transpose #(.LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .lane_in   (lane_in),
    .clear     (clear),
    .valid_out (valid_out),
    .lane_out  (lane_out)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_lane(input string tag, input lane_t obs, input lane_t expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic lane_t pat(input int base, input int i, input int stride);
    lane_t r;
    for (int j = 0; j < L; j++) r[j] = data_t'(base + stride * i + j);
    return r;
  endfunction

  function automatic lane_t col(input int base, input int k, input int stride);
    lane_t r;
    for (int i = 0; i < L; i++) r[i] = data_t'(base + stride * i + k);
    return r;
  endfunction

  task automatic model_clear();
    blk_q.delete();
    pend_q.delete();
    exp_v = 1'b0;
  endtask

  task automatic step(input logic v, input lane_t d, input logic clr);
    lane_t t;
    valid_in = v;
    lane_in  = d;
    clear    = clr;
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      if (v) begin
        blk_q.push_back(d);
        if (blk_q.size() == L) begin
          for (int k = 0; k < L; k++) begin
            for (int i = 0; i < L; i++) t[i] = blk_q[i][k];
            pend_q.push_back(t);
          end
          blk_q.delete();
          blocks_done++;
        end
      end
      if (pend_q.size() > 0) begin
        exp_out = pend_q.pop_front();
        exp_v   = 1'b1;
      end else begin
        exp_v = 1'b0;
      end
    end
    #1;
    if (valid_out) dut_valid_cnt++;
    chk_bit("valid_out", valid_out, exp_v);
    chk_lane("lane_out", lane_out, exp_out);
    chk_bit("valid_bound", (dut_valid_cnt <= L * blocks_done), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    int    run;
    int    sent;
    lane_t d;
    logic  v;

    rst_n         = 1'b0;
    valid_in      = 1'b0;
    clear         = 1'b0;
    lane_in       = '0;
    exp_out       = '0;
    dut_valid_cnt = 0;
    blocks_done   = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_valid", valid_out, 1'b0);
    chk_lane("reset_lane", lane_out, '0);
    rst_n = 1'b1;
    idle(2);

    // Gap-free block: output beat k appears right after input beat 7, then contiguous.
    for (int i = 0; i < L; i++) step(1'b1, pat(0, i, 16), 1'b0);
    chk_bit("gapfree_first_valid", valid_out, 1'b1);
    chk_lane("gapfree_beat0", lane_out, col(0, 0, 16));
    for (int k = 1; k < L; k++) begin
      step(1'b0, '0, 1'b0);
      chk_lane("gapfree_beat", lane_out, col(0, k, 16));
    end
    idle(1);
    chk_bit("gapfree_done", valid_out, 1'b0);
    chk_lane("gapfree_hold", lane_out, col(0, L - 1, 16));
    idle(2);

    // Three back-to-back blocks must give 24 contiguous output beats.
    run = 0;
    for (int i = 0; i < 3 * L; i++) begin
      step(1'b1, pat(1000 + 64 * (i / L), i % L, 8), 1'b0);
      if (valid_out) run++;
    end
    for (int c = 0; c < 2 * L; c++) begin
      step(1'b0, '0, 1'b0);
      if (valid_out) run++;
    end
    chk_bit("b2b_count_24", (run == 3 * L), 1'b1);

    // Input gaps every other cycle: output still starts after beat 7, contiguous.
    for (int i = 0; i < L; i++) begin
      step(1'b1, pat(0, i, 16), 1'b0);
      if (i != L - 1) step(1'b0, '0, 1'b0);
    end
    chk_lane("gapped_beat0", lane_out, col(0, 0, 16));
    run = 1;
    for (int c = 0; c < L + 2; c++) begin
      step(1'b0, '0, 1'b0);
      if (valid_out) run++;
    end
    chk_bit("gapped_count_8", (run == L), 1'b1);

    // Partial block aborted by clear (the beat with clear is dropped).
    for (int i = 0; i < 5; i++) step(1'b1, pat(500, i, 8), 1'b0);
    step(1'b1, pat(500, 5, 8), 1'b1);
    chk_bit("clear_valid_low", valid_out, 1'b0);
    for (int i = 0; i < L; i++) step(1'b1, pat(100, i, 8), 1'b0);
    chk_lane("clear_full_beat0", lane_out, col(100, 0, 8));
    idle(L + 2);

    // Reset asserted while output beat 3 is on the bus.
    for (int i = 0; i < L; i++) step(1'b1, pat(0, i, 16), 1'b0);
    idle(3);
    chk_lane("pre_reset_beat3", lane_out, col(0, 3, 16));
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk_bit("async_reset_valid", valid_out, 1'b0);
    chk_lane("async_reset_lane", lane_out, '0);
    model_clear();
    exp_out = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < L; i++) step(1'b1, pat(300, i, 8), 1'b0);
    chk_lane("post_reset_beat0", lane_out, col(300, 0, 8));
    idle(L + 2);

    // Random gapped stream of 64 blocks.
    dut_valid_cnt = 0;
    blocks_done   = 0;
    sent          = 0;
    while (sent < 64 * L) begin
      v = ($urandom_range(0, 99) < 65);
      for (int j = 0; j < L; j++) d[j] = data_t'($urandom);
      step(v, d, 1'b0);
      if (v) sent++;
    end
    idle(2 * L + 2);
    chk_bit("random_blocks_64", (blocks_done == 64), 1'b1);
    chk_bit("random_valid_total", (dut_valid_cnt == L * 64), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
